operand_fetch_stage: RTL
========================

Name: operand_fetch_stage

Overview:
- Pipeline stage directly downstream of the 32-bit register-file slices. It drives the two register-file read addresses (Load_addr_1/Load_addr_2) and collects the two 32-bit read buses (Addr_1/Addr_2).
- It bypasses in-flight writebacks, forces r0 and unmapped registers to zero, and registers the operands into a two-entry skid buffer with valid/ready handshakes toward the execute stage.

Parameters:
- DATA_W, 32, operand and register width.
- NUM_REGS, 8, number of register-file slices; valid addresses are 0..NUM_REGS-1.
- OPC_W, 8, width of the opcode carried alongside the operands.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  decoded instruction present.
- in_ready  output  1  stage can accept an instruction this cycle.
- in_opc  input  OPC_W  opcode.
- in_rs1  input  DATA_W  source register 1 number.
- in_rs2  input  DATA_W  source register 2 number.
- in_rd  input  DATA_W  destination register number, passed through.
- load_addr_1  output  DATA_W  register-file read address 1; combinational copy of in_rs1.
- load_addr_2  output  DATA_W  register-file read address 2; combinational copy of in_rs2.
- rf_data_1  input  DATA_W  register-file read bus 1.
- rf_data_2  input  DATA_W  register-file read bus 2.
- wb_en  input  1  a writeback commits to the register file at the next edge.
- wb_reg  input  DATA_W  writeback register number.
- wb_value  input  DATA_W  writeback value.
- out_valid  output  1  operand bundle available.
- out_ready  input  1  execute stage accepts the bundle.
- out_opc  output  OPC_W  opcode of the head entry.
- out_op1  output  DATA_W  operand 1 of the head entry.
- out_op2  output  DATA_W  operand 2 of the head entry.
- out_rd  output  DATA_W  destination register of the head entry.

Behaviour:
- Reset, asynchronous: state EMPTY; out_valid=0; out_opc/out_op1/out_op2/out_rd=0; in_ready=1; skid entry cleared. Reset mid-operation discards both entries; no handshake completes in the reset cycle.
- Operand resolution, combinational, applied per source:
  - If rs==0 or rs>=NUM_REGS, the operand is 0. Unmapped slices leave the bus undriven, so rf_data is ignored in this case.
  - Else, if wb_en and wb_reg==rs, the operand is wb_value. This is forwarding and requires FORWARD_EN.
  - Else, the operand is rf_data.
- Accept occurs when in_valid and in_ready; the resolved bundle is captured at that edge, so latency from accept to out_valid is 1 cycle.
- States:
  - EMPTY: no entries.
  - ONE: head entry valid.
  - TWO: head plus skid entry valid.
- in_ready is registered: in_ready = (state != TWO).
- Transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept + no pop -> TWO; the new bundle goes to skid.
  - ONE + accept + pop -> ONE; the new bundle replaces head.
  - ONE + pop, no accept -> EMPTY.
  - TWO + pop -> ONE; skid moves to head. No accept is possible in TWO.
- Pop occurs when out_valid and out_ready. out_* values are held stable while out_valid=1 and out_ready=0, except for the snoop update below.
- Snoop: every held entry, head and skid, is compared with the writeback each cycle regardless of FORWARD_EN. If wb_en and wb_reg equals the entry's rs1 (or rs2), wb_reg is nonzero and below NUM_REGS, the matching operand is replaced at the edge. Each entry therefore stores rs1/rs2.
- Simultaneous pop and snoop: the popped entry is not updated. An entry moving from skid to head is moved with the snooped value.
- Both sources match wb_reg: both operands are updated or forwarded.

Optional Feature:
- Macro: OPERAND_FETCH_FORWARD_EN.
- Defined: the forwarding rule above is active and in_ready follows the state rule only.
- Undefined: there is no wb_value bypass on the incoming bundle. in_ready is also forced to 0 in any cycle where wb_en=1 and wb_reg equals a nonzero, mapped in_rs1 or in_rs2, which stalls the instruction for one cycle so it reads the committed value. Snooping of held entries is unchanged.

Decomposition:
- Shared package: the state enum (EMPTY/ONE/TWO); the entry struct {opc, rs1, rs2, rd, op1, op2}; the function reg_mapped(rs) (nonzero and below NUM_REGS).
- One sub-module, operand_resolve: a combinational per-source mux covering zero, forward and read-bus selection. It is instantiated twice.

Test Plan:
- Reset, then in_rs1=3 with rf_data_1=0x1234 and in_rs2=0 with rf_data_2=0xFFFF, out_ready=1 -> next cycle out_valid=1, out_op1=0x1234, out_op2=0.
- in_rs1=2 with wb_en=1, wb_reg=2, wb_value=0xAA, rf_data_1=0x11 -> FORWARD_EN: out_op1=0xAA. No macro: in_ready=0 that cycle; the next cycle accepts with rf_data_1=0xAA.
- in_rs2=9 with NUM_REGS=8 and rf_data_2=0xDEAD -> out_op2=0.
- out_ready=0 while 3 instructions are offered on consecutive cycles -> first two accepted, in_ready=0 in the third cycle; out_* stay constant. out_ready=1 for two cycles then drains both entries in order, and the third is accepted.
- Head entry held with rs1=5; wb_en=1, wb_reg=5, wb_value=0x77 -> out_op1 becomes 0x77 the next cycle while out_valid remains 1.
- rst asserted asynchronously while state=TWO -> out_valid=0 and in_ready=1 immediately, with no clock edge; the entries are discarded.

Source files
------------

// File: rtl/operand_fetch_stage_pkg.sv
// operand_fetch_stage_pkg: shared widths, FSM state, skid entry type and helpers for the operand fetch stage
// Macro OPERAND_FETCH_FORWARD_EN selects writeback bypass on the incoming bundle (default: off, stall instead).
package operand_fetch_stage_pkg;
   localparam int DATA_W   = 32;
   localparam int NUM_REGS = 8;
   localparam int OPC_W    = 8;
`ifdef OPERAND_FETCH_FORWARD_EN
   localparam bit FORWARD_EN = 1'b1;
`else
   localparam bit FORWARD_EN = 1'b0;
`endif
   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
   typedef struct packed {
      logic [OPC_W-1:0]  opc;
      logic [DATA_W-1:0] rs1;
      logic [DATA_W-1:0] rs2;
      logic [DATA_W-1:0] rd;
      logic [DATA_W-1:0] op1;
      logic [DATA_W-1:0] op2;
   } entry_t;
   function automatic logic reg_mapped(input logic [DATA_W-1:0] rs);
      return rs != '0 && rs < DATA_W'(NUM_REGS);
   endfunction
   // Refresh a held entry with a writeback that commits at this edge.
   function automatic entry_t snoop(input entry_t e, input logic wb_en,
                                    input logic [DATA_W-1:0] wb_reg, input logic [DATA_W-1:0] wb_value);
      entry_t s;
      s = e;
      if (wb_en && reg_mapped(wb_reg) && wb_reg == e.rs1) s.op1 = wb_value;
      if (wb_en && reg_mapped(wb_reg) && wb_reg == e.rs2) s.op2 = wb_value;
      return s;
   endfunction
endpackage

// File: rtl/operand_fetch_stage_if.sv
// operand_fetch_stage_if: decode-side, register-file, writeback and execute-side signals of the operand fetch stage
// master: drives in_*, rf_data_*, wb_*, out_ready; slave (the stage): drives in_ready, load_addr_*, out_*.
interface operand_fetch_stage_if;
   import operand_fetch_stage_pkg::*;
   logic              in_valid;
   logic              in_ready;
   logic [OPC_W-1:0]  in_opc;
   logic [DATA_W-1:0] in_rs1;
   logic [DATA_W-1:0] in_rs2;
   logic [DATA_W-1:0] in_rd;
   logic [DATA_W-1:0] load_addr_1;
   logic [DATA_W-1:0] load_addr_2;
   logic [DATA_W-1:0] rf_data_1;
   logic [DATA_W-1:0] rf_data_2;
   logic              wb_en;
   logic [DATA_W-1:0] wb_reg;
   logic [DATA_W-1:0] wb_value;
   logic              out_valid;
   logic              out_ready;
   logic [OPC_W-1:0]  out_opc;
   logic [DATA_W-1:0] out_op1;
   logic [DATA_W-1:0] out_op2;
   logic [DATA_W-1:0] out_rd;
   modport master (
      output in_valid, in_opc, in_rs1, in_rs2, in_rd, rf_data_1, rf_data_2, wb_en, wb_reg, wb_value, out_ready,
      input  in_ready, load_addr_1, load_addr_2, out_valid, out_opc, out_op1, out_op2, out_rd
   );
   modport slave (
      input  in_valid, in_opc, in_rs1, in_rs2, in_rd, rf_data_1, rf_data_2, wb_en, wb_reg, wb_value, out_ready,
      output in_ready, load_addr_1, load_addr_2, out_valid, out_opc, out_op1, out_op2, out_rd
   );
endinterface

// File: rtl/operand_fetch_stage_resolve.sv
// operand_resolve: per-source operand mux (zero for r0/unmapped, optional writeback bypass, else read bus)
// Ports: i_rs source number, i_rf_data read bus, i_wb_* writeback; o_op resolved operand, o_hit writeback targets i_rs.
module operand_resolve
   import operand_fetch_stage_pkg::*;
(
   input  logic [DATA_W-1:0] i_rs,
   input  logic [DATA_W-1:0] i_rf_data,
   input  logic              i_wb_en,
   input  logic [DATA_W-1:0] i_wb_reg,
   input  logic [DATA_W-1:0] i_wb_value,
   output logic [DATA_W-1:0] o_op,
   output logic              o_hit
);
   logic w_mapped;
   assign w_mapped = reg_mapped(i_rs);
   assign o_hit    = i_wb_en && w_mapped && i_wb_reg == i_rs;
   // Unmapped slices leave the bus floating, so it is never selected for them.
   assign o_op     = !w_mapped ? '0 : (FORWARD_EN && o_hit) ? i_wb_value : i_rf_data;
endmodule

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: reads two register-file operands, resolves bypass/zero rules and buffers them in a 2-entry skid buffer
// Ports: clk, rst (async, active-high), bus (operand_fetch_stage_if.slave). Macro: OPERAND_FETCH_FORWARD_EN.
module operand_fetch_stage
   import operand_fetch_stage_pkg::*;
(
   input logic                  clk,
   input logic                  rst,
   operand_fetch_stage_if.slave bus
);
   state_t            r_state;
   entry_t            r_head;
   entry_t            r_skid;
   logic              r_out_valid;
   logic              r_in_ready;
   logic [DATA_W-1:0] w_op1;
   logic [DATA_W-1:0] w_op2;
   logic              w_hit1;
   logic              w_hit2;
   logic              w_stall;
   logic              w_accept;
   logic              w_pop;
   entry_t            w_new;
   entry_t            w_head_s;
   entry_t            w_skid_s;
   operand_resolve u_res1 (
      .i_rs(bus.in_rs1), .i_rf_data(bus.rf_data_1), .i_wb_en(bus.wb_en),
      .i_wb_reg(bus.wb_reg), .i_wb_value(bus.wb_value), .o_op(w_op1), .o_hit(w_hit1)
   );
   operand_resolve u_res2 (
      .i_rs(bus.in_rs2), .i_rf_data(bus.rf_data_2), .i_wb_en(bus.wb_en),
      .i_wb_reg(bus.wb_reg), .i_wb_value(bus.wb_value), .o_op(w_op2), .o_hit(w_hit2)
   );
   // Without bypass, hold the instruction one cycle so it reads the committed value.
   assign w_stall         = !FORWARD_EN && (w_hit1 || w_hit2);
   assign bus.in_ready    = r_in_ready && !w_stall;
   assign w_accept        = bus.in_valid && bus.in_ready;
   assign w_pop           = r_out_valid && bus.out_ready;
   assign w_new           = '{bus.in_opc, bus.in_rs1, bus.in_rs2, bus.in_rd, w_op1, w_op2};
   assign w_head_s        = snoop(r_head, bus.wb_en, bus.wb_reg, bus.wb_value);
   assign w_skid_s        = snoop(r_skid, bus.wb_en, bus.wb_reg, bus.wb_value);
   assign bus.load_addr_1 = bus.in_rs1;
   assign bus.load_addr_2 = bus.in_rs2;
   assign bus.out_valid   = r_out_valid;
   assign bus.out_opc     = r_head.opc;
   assign bus.out_op1     = r_head.op1;
   assign bus.out_op2     = r_head.op2;
   assign bus.out_rd      = r_head.rd;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_state     <= EMPTY;
         r_head      <= '0;
         r_skid      <= '0;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
      end else
         case (r_state)
            EMPTY:
               if (w_accept) begin
                  r_head      <= w_new;
                  r_state     <= ONE;
                  r_out_valid <= 1'b1;
               end
            ONE:
               if (w_accept && !w_pop) begin
                  r_head     <= w_head_s;
                  r_skid     <= w_new;
                  r_state    <= TWO;
                  r_in_ready <= 1'b0;
               end else if (w_accept)
                  r_head <= w_new;
               else if (w_pop) begin
                  r_state     <= EMPTY;
                  r_out_valid <= 1'b0;
               end else
                  r_head <= w_head_s;
            TWO:
               if (w_pop) begin
                  r_head     <= w_skid_s;
                  r_state    <= ONE;
                  r_in_ready <= 1'b1;
               end else begin
                  r_head <= w_head_s;
                  r_skid <= w_skid_s;
               end
            default: r_state <= EMPTY;
         endcase
endmodule
